// File: rtl/regs_wb_sched_pkg.sv
// Shared constants and helpers for the register-file write-back scheduler.
// Imported by the arbiter and the scheduler top.
package regs_wb_sched_pkg;

   localparam int REG_ZERO       = 0;
   localparam int DEF_WIDTH      = 32;
   localparam int DEF_NR_REGS    = 32;
   localparam int DEF_ADDR_WIDTH = 5;
   localparam int MAX_REQ        = 8;

   // Index of the set bit in a one-hot vector (0 when none is set).
   function automatic logic [2:0] onehot_to_idx(input logic [MAX_REQ-1:0] oh);
      logic [2:0] idx;
      idx = '0;
      for (int i = 0; i < MAX_REQ; i++) begin
         if (oh[i]) idx = idx | 3'(i);
      end
      return idx;
   endfunction

endpackage

// File: rtl/regs_wb_sched_rr_arbiter.sv
// Round-robin arbiter: one-hot grant searched from the slot after the
// last winner; the pointer moves only when the caller signals advance.
import regs_wb_sched_pkg::*;

module rr_arbiter #(
   parameter int N = 3
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic [N-1:0]         req,
   output logic [N-1:0]         grant,
   output logic [$clog2(N)-1:0] grant_idx,
   input  logic                 advance
);

   localparam int IW = $clog2(N);

   logic [IW-1:0] last_q;
   logic [IW-1:0] last_d;
   logic          hit;
   int            cand;

   // Pick the first requester after the last winner, wrapping around.
   always_comb begin
      grant = '0;
      hit   = 1'b0;
      cand  = 0;
      for (int k = 1; k <= N; k++) begin
         cand = (int'(last_q) + k) % N;
         if (!hit && req[cand]) begin
            grant[cand] = 1'b1;
            hit         = 1'b1;
         end
      end
      grant_idx = IW'(onehot_to_idx(MAX_REQ'(grant)));
      last_d    = advance ? grant_idx : last_q;
   end

   // Last-grant pointer; reset so requester 0 wins first.
   always_ff @(posedge clk) begin
      if (rst) last_q <= IW'(N - 1);
      else     last_q <= last_d;
   end

endmodule

// File: rtl/regs_wb_sched.sv
// Write-back scheduler: arbitrates producers onto the single register-file
// write port and tracks reserved destinations for read-hazard stalls.
import regs_wb_sched_pkg::*;

module regs_wb_sched #(
   parameter int NR_REQ     = 3,
   parameter int WIDTH      = DEF_WIDTH,
   parameter int NR_REGS    = DEF_NR_REGS,
   parameter int ADDR_WIDTH = DEF_ADDR_WIDTH
) (
   input  logic                         clk,
   input  logic                         rst,
   input  logic [NR_REQ-1:0]            req_valid,
   output logic [NR_REQ-1:0]            req_ready,
   input  logic [NR_REQ*ADDR_WIDTH-1:0] req_addr,
   input  logic [NR_REQ*WIDTH-1:0]      req_data,
   input  logic                         issue_valid,
   input  logic [ADDR_WIDTH-1:0]        issue_addr,
   output logic                         issue_ready,
   input  logic [ADDR_WIDTH-1:0]        qa_addr,
   input  logic [ADDR_WIDTH-1:0]        qb_addr,
   output logic                         busy_a,
   output logic                         busy_b,
   output logic                         wen,
   output logic [ADDR_WIDTH-1:0]        addrw,
   output logic [WIDTH-1:0]             dinw
);

   logic [NR_REQ-1:0]         grant;
   logic [$clog2(NR_REQ)-1:0] gidx;
   logic                      hs;
   logic [ADDR_WIDTH-1:0]     sel_addr;
   logic [WIDTH-1:0]          sel_data;

   logic                      wen_q, wen_d;
   logic [ADDR_WIDTH-1:0]     addrw_q, addrw_d;
   logic [WIDTH-1:0]          dinw_q, dinw_d;
   logic [NR_REGS-1:0]        busy_q, busy_d;

   rr_arbiter #(.N(NR_REQ)) u_arb (
      .clk       (clk),
      .rst       (rst),
      .req       (req_valid),
      .grant     (grant),
      .grant_idx (gidx),
      .advance   (hs)
   );

   // Grant is only raised for a valid requester, so it doubles as ready.
   always_comb begin
      req_ready = grant;
      hs        = |grant;
      sel_addr  = req_addr[int'(gidx)*ADDR_WIDTH +: ADDR_WIDTH];
      sel_data  = req_data[int'(gidx)*WIDTH +: WIDTH];
   end

   // Stage the winner; writes to the zero register are swallowed here.
   always_comb begin
      wen_d   = hs && (sel_addr != ADDR_WIDTH'(REG_ZERO));
      addrw_d = hs ? sel_addr : addrw_q;
      dinw_d  = hs ? sel_data : dinw_q;
   end

   // Reserve on issue, release when the staged write commits.
   always_comb begin
      issue_ready = issue_valid && !busy_q[issue_addr];
      busy_d      = busy_q;
      if (wen_q)       busy_d[addrw_q]    = 1'b0;
      if (issue_ready) busy_d[issue_addr] = 1'b1;
      busy_d[REG_ZERO] = 1'b0;
      busy_a = busy_q[qa_addr];
      busy_b = busy_q[qb_addr];
   end

   // Write stage and scoreboard registers.
   always_ff @(posedge clk) begin
      if (rst) begin
         wen_q   <= 1'b0;
         addrw_q <= '0;
         dinw_q  <= '0;
         busy_q  <= '0;
      end else begin
         wen_q   <= wen_d;
         addrw_q <= addrw_d;
         dinw_q  <= dinw_d;
         busy_q  <= busy_d;
      end
   end

   assign wen   = wen_q;
   assign addrw = addrw_q;
   assign dinw  = dinw_q;

endmodule

// File: tb/tb_regs_wb_sched.sv
// Bench for regs_wb_sched: directed scenarios plus random traffic,
// all checked against a behavioural reservation/arbitration model.
module tb_regs_wb_sched;

   localparam int NR = 3;
   localparam int AW = 5;
   localparam int DW = 32;

   logic             clk = 1'b0;
   logic             rst;
   logic [NR-1:0]    req_valid;
   logic [NR-1:0]    req_ready;
   logic [NR*AW-1:0] req_addr;
   logic [NR*DW-1:0] req_data;
   logic             issue_valid;
   logic [AW-1:0]    issue_addr;
   logic             issue_ready;
   logic [AW-1:0]    qa_addr;
   logic [AW-1:0]    qb_addr;
   logic             busy_a;
   logic             busy_b;
   logic             wen;
   logic [AW-1:0]    addrw;
   logic [DW-1:0]    dinw;

   regs_wb_sched dut (
      .clk         (clk),
      .rst         (rst),
      .req_valid   (req_valid),
      .req_ready   (req_ready),
      .req_addr    (req_addr),
      .req_data    (req_data),
      .issue_valid (issue_valid),
      .issue_addr  (issue_addr),
      .issue_ready (issue_ready),
      .qa_addr     (qa_addr),
      .qb_addr     (qb_addr),
      .busy_a      (busy_a),
      .busy_b      (busy_b),
      .wen         (wen),
      .addrw       (addrw),
      .dinw        (dinw)
   );

   always #5 clk = ~clk;

   int n_tests = 0;
   int n_fail  = 0;

   // Reference model state
   int            last_m;
   bit            busy_m [32];
   bit            wen_m;
   logic [AW-1:0] addrw_m;
   logic [DW-1:0] dinw_m;

   // Last observed values for the directed scenarios
   logic [NR-1:0] obs_ready;
   logic          obs_ir, obs_ba, obs_bb, obs_wen;
   logic [AW-1:0] obs_addrw;
   logic [DW-1:0] obs_dinw;

   task automatic chk(input string tag, input logic [63:0] got,
                      input logic [63:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic model_reset();
      last_m  = NR - 1;
      wen_m   = 1'b0;
      addrw_m = '0;
      dinw_m  = '0;
      foreach (busy_m[i]) busy_m[i] = 1'b0;
   endtask

   task automatic idle();
      rst         = 1'b0;
      req_valid   = '0;
      req_addr    = '0;
      req_data    = '0;
      issue_valid = 1'b0;
      issue_addr  = '0;
      qa_addr     = '0;
      qb_addr     = '0;
   endtask

   task automatic set_req(input int r, input logic [AW-1:0] a,
                          input logic [DW-1:0] d);
      req_valid[r]        = 1'b1;
      req_addr[r*AW +: AW] = a;
      req_data[r*DW +: DW] = d;
   endtask

   task automatic issue(input logic [AW-1:0] a);
      issue_valid = 1'b1;
      issue_addr  = a;
   endtask

   // One clock: check combinational outputs, step model, check write stage.
   task automatic cycle();
      int            win;
      int            i;
      logic [NR-1:0] exp_ready;
      bit            exp_ir;
      logic [AW-1:0] a;
      #1;
      win = -1;
      for (int k = 1; k <= NR; k++) begin
         i = (last_m + k) % NR;
         if (win < 0 && req_valid[i]) win = i;
      end
      exp_ready = '0;
      if (win >= 0) exp_ready[win] = 1'b1;
      exp_ir = issue_valid && !busy_m[issue_addr];
      chk("req_ready", req_ready, exp_ready);
      chk("issue_ready", issue_ready, exp_ir);
      chk("busy_a", busy_a, busy_m[qa_addr]);
      chk("busy_b", busy_b, busy_m[qb_addr]);
      obs_ready = req_ready;
      obs_ir    = issue_ready;
      obs_ba    = busy_a;
      obs_bb    = busy_b;
      @(posedge clk);
      if (rst) begin
         model_reset();
      end else begin
         if (wen_m) busy_m[addrw_m] = 1'b0;
         if (exp_ir && issue_addr != 0) busy_m[issue_addr] = 1'b1;
         if (win >= 0) begin
            last_m  = win;
            a       = req_addr[win*AW +: AW];
            wen_m   = (a != 0);
            addrw_m = a;
            dinw_m  = req_data[win*DW +: DW];
         end else begin
            wen_m = 1'b0;
         end
      end
      #1;
      chk("wen", wen, wen_m);
      if (wen_m) begin
         chk("addrw", addrw, addrw_m);
         chk("dinw", dinw, dinw_m);
      end
      obs_wen   = wen;
      obs_addrw = addrw;
      obs_dinw  = dinw;
   endtask

   initial begin
      idle();
      model_reset();
      rst = 1'b1;
      cycle();
      chk("rst_addrw", addrw, 0);
      chk("rst_dinw", dinw, 0);
      rst = 1'b0;

      // Round-robin over all three requesters
      set_req(0, 5'd1, 32'h11);
      set_req(1, 5'd2, 32'h22);
      set_req(2, 5'd3, 32'h33);
      cycle(); chk("rr_g0", obs_ready, 3'b001);
      cycle(); chk("rr_g1", obs_ready, 3'b010);
      cycle(); chk("rr_g2", obs_ready, 3'b100);
      cycle(); chk("rr_g3", obs_ready, 3'b001);
      chk("rr_w3", obs_addrw, 5'd1);

      // Reserve x5, then write it back
      idle(); issue(5'd5);
      cycle(); chk("x5_ir", obs_ir, 1);
      idle(); qa_addr = 5'd5;
      set_req(1, 5'd5, 32'hDEADBEEF);
      cycle(); chk("x5_busy", obs_ba, 1);
      chk("x5_wen", obs_wen, 1);
      chk("x5_dinw", obs_dinw, 32'hDEADBEEF);
      idle(); qa_addr = 5'd5;
      cycle(); chk("x5_busy_commit", obs_ba, 1);
      cycle(); chk("x5_clear", obs_ba, 0);

      // Double reservation of x7 is refused until commit
      idle(); issue(5'd7);
      cycle(); chk("x7_ir1", obs_ir, 1);
      cycle(); chk("x7_ir2", obs_ir, 0);
      idle(); set_req(0, 5'd7, 32'h77);
      cycle();
      idle();
      cycle();
      issue(5'd7);
      cycle(); chk("x7_ir3", obs_ir, 1);

      // Write to x0 is accepted and dropped
      idle(); set_req(2, 5'd0, 32'h1234);
      cycle(); chk("x0_ready", obs_ready, 3'b100);
      chk("x0_wen", obs_wen, 0);

      // Set x9 while x4 commits
      idle(); issue(5'd4);
      cycle();
      idle(); set_req(0, 5'd4, 32'h44);
      cycle();
      idle(); issue(5'd9); qa_addr = 5'd9; qb_addr = 5'd4;
      cycle(); chk("x4_busy_pre", obs_bb, 1);
      idle(); qa_addr = 5'd9; qb_addr = 5'd4;
      cycle(); chk("x9_set", obs_ba, 1);
      chk("x4_clear", obs_bb, 0);

      // Reset right after a handshake
      idle(); issue(5'd3);
      cycle();
      idle(); set_req(1, 5'd10, 32'hAA);
      cycle();
      idle(); rst = 1'b1;
      cycle(); chk("rst_wen", obs_wen, 0);
      idle(); qa_addr = 5'd3; qb_addr = 5'd9;
      set_req(0, 5'd1, 32'h1);
      set_req(1, 5'd2, 32'h2);
      set_req(2, 5'd3, 32'h3);
      cycle(); chk("rst_grant", obs_ready, 3'b001);
      chk("rst_busy3", obs_ba, 0);
      chk("rst_busy9", obs_bb, 0);

      // Random traffic
      for (int n = 0; n < 500; n++) begin
         idle();
         rst = ($urandom_range(0, 63) == 0);
         for (int r = 0; r < NR; r++) begin
            if ($urandom_range(0, 1) == 1)
               set_req(r, 5'($urandom_range(0, 31)), $urandom);
         end
         if ($urandom_range(0, 1) == 1) issue(5'($urandom_range(0, 31)));
         qa_addr = 5'($urandom_range(0, 31));
         qb_addr = 5'($urandom_range(0, 31));
         cycle();
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
